// File: rtl/uba_reg_decode.sv
// uba_reg_decode: UBA backplane register-access sequencer issuing one-shot strobes and ack
module uba_reg_decode #(
  parameter logic [3:0]  ubaNUM    = 4'o1,
  parameter logic [17:0] pageBASE  = 18'o763000,
  parameter logic [17:0] statADDR  = 18'o763100,
  parameter logic [17:0] maintADDR = 18'o763101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busREQI,
  input  logic        busIO,
  input  logic        busREAD,
  input  logic        busWRITE,
  input  logic [0:35] busADDRI,
  input  logic [0:35] busDATAI,
  input  logic [0:35] pageDATA,
  input  logic [0:35] regUBASR,
  output logic        busACKO,
  output logic [0:35] busDATAO,
  output logic [0:5]  pageADDR,
  output logic        pageREAD,
  output logic        pageWRITE,
  output logic        statusWRITE,
  output logic        maintWRITE
);
  typedef enum logic [1:0] {IDLE, ACCESS, PGRD, WAIT} state_t;
  state_t state, state_n;
  logic prd, prd_n, pg, st, mt, match;
  logic ack_n, pr_n, pw_n, sw_n, mw_n;
  logic [0:35] dato_n;
  logic [0:5] pa_n;
  logic [17:0] a;
  logic unused;
  assign unused = ^{busDATAI, busADDRI[0:13]};
  assign a = busADDRI[18:35];
  assign pg = (a >= pageBASE) && (a < pageBASE + 18'd64);
  assign st = a == statADDR;
  assign mt = a == maintADDR;
  assign match = busREQI & busIO & (busREAD ^ busWRITE) & (busADDRI[14:17] == ubaNUM) & (pg | st | mt);
  // Outputs are computed one state ahead so every strobe and ack leaves a flop
  always_comb begin
    state_n = state;
    prd_n = prd;
    pa_n = pageADDR;
    dato_n = busDATAO;
    ack_n = 1'b0;
    pr_n = 1'b0;
    pw_n = 1'b0;
    sw_n = 1'b0;
    mw_n = 1'b0;
    case (state)
      IDLE: if (match) begin
        state_n = ACCESS;
        prd_n = busREAD & pg;
        pa_n = busADDRI[30:35];
        pw_n = busWRITE & pg;
        sw_n = busWRITE & st;
        mw_n = busWRITE & mt;
        pr_n = busREAD & pg;
        ack_n = ~(busREAD & pg);
        dato_n = (busREAD & st) ? regUBASR : (busREAD & mt) ? 36'b0 : busDATAO;
      end
      ACCESS: begin
        state_n = prd ? PGRD : WAIT;
        ack_n = prd;
        dato_n = prd ? pageDATA : busDATAO;
      end
      PGRD: state_n = WAIT;
      WAIT: state_n = busREQI ? WAIT : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      prd <= 1'b0;
      pageADDR <= '0;
      busDATAO <= '0;
      busACKO <= 1'b0;
      pageREAD <= 1'b0;
      pageWRITE <= 1'b0;
      statusWRITE <= 1'b0;
      maintWRITE <= 1'b0;
    end else begin
      state <= state_n;
      prd <= prd_n;
      pageADDR <= pa_n;
      busDATAO <= dato_n;
      busACKO <= ack_n;
      pageREAD <= pr_n;
      pageWRITE <= pw_n;
      statusWRITE <= sw_n;
      maintWRITE <= mw_n;
    end
endmodule

// File: tb/tb_uba_reg_decode.sv
// tb_uba_reg_decode: directed checks of strobe/ack timing, read data and address decode
module tb_uba_reg_decode;
  logic clk = 1'b0, rst = 1'b1;
  logic busREQI = 0, busIO = 0, busREAD = 0, busWRITE = 0;
  logic [0:35] busADDRI = '0, busDATAI = '0, pageDATA = '0, regUBASR = '0;
  logic busACKO, pageREAD, pageWRITE, statusWRITE, maintWRITE;
  logic [0:35] busDATAO;
  logic [0:5] pageADDR;
  logic [4:0] s, acc;
  int total = 0, bad = 0;

  uba_reg_decode dut (
    .clk(clk), .rst(rst), .busREQI(busREQI), .busIO(busIO), .busREAD(busREAD),
    .busWRITE(busWRITE), .busADDRI(busADDRI), .busDATAI(busDATAI), .pageDATA(pageDATA),
    .regUBASR(regUBASR), .busACKO(busACKO), .busDATAO(busDATAO), .pageADDR(pageADDR),
    .pageREAD(pageREAD), .pageWRITE(pageWRITE), .statusWRITE(statusWRITE), .maintWRITE(maintWRITE)
  );

  always #5 clk = ~clk;
  // Strobe vector: {ack, pageREAD, pageWRITE, statusWRITE, maintWRITE}
  assign s = {busACKO, pageREAD, pageWRITE, statusWRITE, maintWRITE};

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic io, input logic rd, input logic wr, input logic [3:0] u, input logic [17:0] a);
    busREQI = 1'b1;
    busIO = io;
    busREAD = rd;
    busWRITE = wr;
    busADDRI = {14'b0, u, a};
  endtask

  task automatic release_req();
    busREQI = 1'b0;
    busREAD = 1'b0;
    busWRITE = 1'b0;
    tick();
    tick();
  endtask

  task automatic quiet(input string tag);
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc |= s;
    end
    chk(tag, acc, 5'b0);
    release_req();
  endtask

  initial begin
    tick();
    tick();
    chk("reset_strobes", s, 5'b0);
    chk("reset_data", busDATAO, 36'b0);
    chk("reset_pageaddr", pageADDR, 6'd0);
    rst = 1'b0;
    tick();
    // maintenance write, request held 5 cycles
    busDATAI = 36'o000000000001;
    req(1, 0, 1, 4'o1, 18'o763101);
    tick();
    chk("maint_wr_n1", s, 5'b10001);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc |= s;
    end
    chk("maint_wr_oneshot", acc, 5'b0);
    chk("maint_wr_data_kept", busDATAO, 36'b0);
    release_req();
    // status read
    regUBASR = 36'o123456701234;
    req(1, 1, 0, 4'o1, 18'o763100);
    tick();
    chk("stat_rd_n1", s, 5'b10000);
    chk("stat_rd_data", busDATAO, 36'o123456701234);
    regUBASR = 36'o111111111111;
    tick();
    tick();
    chk("stat_rd_after", s, 5'b0);
    chk("stat_rd_hold", busDATAO, 36'o123456701234);
    release_req();
    // maintenance read returns zero
    req(1, 1, 0, 4'o1, 18'o763101);
    tick();
    chk("maint_rd_n1", s, 5'b10000);
    chk("maint_rd_data", busDATAO, 36'b0);
    release_req();
    // page read at top of window
    pageDATA = 36'o777000000017;
    req(1, 1, 0, 4'o1, 18'o763077);
    tick();
    chk("pg_rd_n1", s, 5'b01000);
    chk("pg_rd_addr", pageADDR, 6'd63);
    chk("pg_rd_data_old", busDATAO, 36'b0);
    tick();
    chk("pg_rd_n2", s, 5'b10000);
    chk("pg_rd_data", busDATAO, 36'o777000000017);
    tick();
    chk("pg_rd_n3", s, 5'b0);
    release_req();
    // non-matching requests
    req(1, 1, 0, 4'o2, 18'o763100);
    quiet("nm_ctrl2");
    req(1, 1, 0, 4'o1, 18'o763102);
    quiet("nm_addr102");
    req(0, 1, 0, 4'o1, 18'o763100);
    quiet("nm_noio");
    req(1, 1, 1, 4'o1, 18'o763100);
    quiet("nm_rdwr");
    chk("nm_data_kept", busDATAO, 36'o777000000017);
    // reset during the ACCESS cycle of a status write
    req(1, 0, 1, 4'o1, 18'o763100);
    tick();
    chk("rst_pre", s, 5'b10010);
    rst = 1'b1;
    busREQI = 1'b0;
    busWRITE = 1'b0;
    #1;
    chk("rst_async", s, 5'b0);
    chk("rst_async_data", busDATAO, 36'b0);
    tick();
    tick();
    chk("rst_held", s, 5'b0);
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc |= s;
    end
    chk("rst_post_quiet", acc, 5'b0);
    req(1, 0, 1, 4'o1, 18'o763100);
    tick();
    chk("rst_fresh_n1", s, 5'b10010);
    tick();
    chk("rst_fresh_n2", s, 5'b0);
    release_req();
    // back-to-back page writes with one idle request cycle
    req(1, 0, 1, 4'o1, 18'o763000);
    tick();
    chk("pw0", s, 5'b10100);
    chk("pw0_addr", pageADDR, 6'd0);
    tick();
    chk("pw0_off", s, 5'b0);
    busREQI = 1'b0;
    tick();
    req(1, 0, 1, 4'o1, 18'o763001);
    tick();
    chk("pw1", s, 5'b10100);
    chk("pw1_addr", pageADDR, 6'd1);
    tick();
    chk("pw1_off", s, 5'b0);
    chk("pw_data_kept", busDATAO, 36'b0);
    release_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uba_reg_decode.md
# uba_reg_decode

Register-access sequencer for the Unibus Adapter (UBA) that sits between the KS-10 backplane bus and the UBA internal registers. It recognises backplane I/O cycles addressed to this UBA and issues single-cycle write strobes to the page RAM, status register and maintenance register. One such strobe, `maintWRITE`, feeds the maintenance register block directly. It also returns read data and generates the one-cycle `busACKO` handshake, with exactly one access performed per backplane request.

## Interface
Parameters:
- `ubaNUM`, default 4'o1: UBA controller number, compared against address bits [14:17].
- `pageBASE`, default 18'o763000: base of the 64-entry paging RAM window, 18'o763000–18'o763077.
- `statADDR`, default 18'o763100: UBA status register address.
- `maintADDR`, default 18'o763101: UBA maintenance register address.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset. Asynchronous, active-high.
- `busREQI` in 1: backplane request. A level signal, held by the master until it sees `busACKO`.
- `busIO` in 1: the request is an I/O cycle.
- `busREAD` in 1: read cycle flag.
- `busWRITE` in 1: write cycle flag.
- `busADDRI` in [0:35]: backplane address. Only [14:35] are used.
- `busDATAI` in [0:35]: write data. Routed externally to the register blocks.
- `pageDATA` in [0:35]: page RAM read data, valid one cycle after `pageREAD`.
- `regUBASR` in [0:35]: current status register contents.
- `busACKO` out 1: one-cycle acknowledge.
- `busDATAO` out [0:35]: read data, held until the next read is acknowledged.
- `pageADDR` out [0:5]: page RAM index, registered.
- `pageREAD` out 1: page RAM read strobe.
- `pageWRITE` out 1: page RAM write strobe.
- `statusWRITE` out 1: status register write strobe.
- `maintWRITE` out 1: maintenance register write strobe.

## Operation
- Address match requires all of the following:
  - `busREQI & busIO`.
  - `busADDRI[14:17] == ubaNUM`.
  - `busADDRI[18:35]` falls in the page window, equals `statADDR`, or equals `maintADDR`.
- Exactly one of `busREAD` or `busWRITE` must be set. If both or neither is set, the request is treated as a non-match.
- State machine states: IDLE, ACCESS, PGRD, WAIT.
- IDLE:
  - On a match, latch the target (page/status/maint), direction and `pageADDR = busADDRI[30:35]`, then go to ACCESS.
  - On no match, stay in IDLE. No strobe and no ack are issued; the bus timeout elsewhere handles NXM.
- ACCESS, write cycles:
  - Pulse the one matching strobe for exactly one cycle.
  - Assert `busACKO` in the same cycle.
  - Go to WAIT.
- ACCESS, status read: load `busDATAO = regUBASR`, assert `busACKO`, go to WAIT.
- ACCESS, maintenance read: load `busDATAO = 36'b0` (CR reads as 0), assert `busACKO`, go to WAIT.
- ACCESS, page read: pulse `pageREAD` and go to PGRD.
- PGRD: load `busDATAO = pageDATA`, assert `busACKO`, go to WAIT.
- WAIT: stay in WAIT while `busREQI` is high, which prevents repeated strobes. Go to IDLE when `busREQI` is low.
- At most one strobe is asserted in any cycle. Strobes never assert outside ACCESS.

## Timing
- Reset values (asynchronous, all outputs registered):
  - state = IDLE.
  - `busACKO`, all strobes = 0.
  - `busDATAO` = 36'b0.
  - `pageADDR` = 0.
- Write / status read / maint read: request sampled at edge N; strobe and `busACKO` high in cycle N+1.
- Page read: request sampled at edge N; `pageREAD` in cycle N+1; `busACKO` and new `busDATAO` in cycle N+2.
- `busDATAO` changes only in the cycle that acks a read. Writes leave it unchanged.
- Minimum request spacing: a new request is accepted no earlier than one cycle after `busREQI` is observed low in WAIT.
- If `busREQI` drops during ACCESS or PGRD, the access still completes (strobe and ack issued), then the FSM passes through WAIT to IDLE.
- Reset asserted mid-access: outputs clear immediately and no strobe is issued after reset is released until a new request arrives.
- Page index wrap: address 18'o763077 maps to `pageADDR` 63. Address 18'o763100 is the status register, not page 64.

## Test plan
- Write 36'o000000000001 to 18'o763101 on ubaNUM=1 with `busREQI` held 5 cycles -> `maintWRITE` high exactly 1 cycle at N+1, `busACKO` 1 cycle at N+1, no other strobe, FSM returns to IDLE after `busREQI` falls.
- Status read, `regUBASR`=36'o123456701234 -> `busACKO` at N+1 and `busDATAO`=36'o123456701234 from N+1 until the next read ack.
- Page read of 18'o763077 with `pageDATA`=36'o777000000017 -> `pageREAD` at N+1 with `pageADDR`=63, `busACKO` and `busDATAO`=36'o777000000017 at N+2.
- Mismatches: controller number 2, address 18'o763102, `busIO`=0, both READ and WRITE set -> no ack and no strobes for 10 cycles in each case.
- Assert `rst` in the ACCESS cycle of a status write -> `statusWRITE`/`busACKO` low while reset is held. After release, no strobe until a fresh request, after which normal one-shot behaviour resumes.
- Back-to-back writes to page 0 and page 1, with `busREQI` low 1 cycle between them -> two `pageWRITE` pulses with `pageADDR` 0 then 1, and two acks.
